// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default sizing for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam int MAX_WAIT_DEF = 15;
    localparam int CNT_W_DEF    = 16;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds the instruction in ID.
// Purely combinational; register 0 never creates a hazard.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       MemRead_EX,
    input  logic [4:0] wrin_EX,
    input  logic [4:0] rs_ID,
    input  logic [4:0] rt_ID,
    input  logic       uses_rt_ID,
    output logic       load_use
);

    assign load_use = MemRead_EX && (wrin_EX != 5'd0) &&
                      ((wrin_EX == rs_ID) || (uses_rt_ID && (wrin_EX == rt_ID)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stage enables/flushes for mem stalls, branches, load-use; memory timeout -> sticky ERR.
// Outputs are combinational from state/inputs; PIPE_CTRL_PERF_EN builds the saturating stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             MemRead_EX,
    input  logic [4:0]       wrin_EX,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             uses_rt_ID,
    input  logic             Branch_MEM,
    input  logic             ZERO_MEM,
    input  logic             MemRead_MEM,
    input  logic             MemWrite_MEM,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             pc_en,
    output logic             en_IF_ID,
    output logic             en_ID_EX,
    output logic             en_EX_MEM,
    output logic             en_MEM_WB,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_EX_MEM,
    output logic             flush_MEM_WB,
    output logic             pc_src,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt, wait_inc;
    logic              load_use, mem_acc, mem_stall, br_taken;

    hazard_detect u_hazard (
        .MemRead_EX (MemRead_EX),
        .wrin_EX    (wrin_EX),
        .rs_ID      (rs_ID),
        .rt_ID      (rt_ID),
        .uses_rt_ID (uses_rt_ID),
        .load_use   (load_use)
    );

    assign mem_acc   = MemRead_MEM | MemWrite_MEM;
    assign mem_stall = mem_acc & ~mem_ack & (state != ERR);
    assign br_taken  = Branch_MEM & ZERO_MEM;
    // Counter sits at 0 in RUN, so the first stalled cycle counts as wait cycle 1.
    assign wait_inc  = wait_cnt + WAIT_W'(1);
    assign mem_err   = (state == ERR);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_nxt     = wait_cnt;
        mem_req      = mem_acc;
        pc_en        = 1'b1;
        en_IF_ID     = 1'b1;
        en_ID_EX     = 1'b1;
        en_EX_MEM    = 1'b1;
        en_MEM_WB    = 1'b1;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        flush_EX_MEM = 1'b0;
        flush_MEM_WB = 1'b0;
        pc_src       = 1'b0;

        if (RESET) begin
            mem_req      = 1'b0;
            pc_en        = 1'b0;
            en_IF_ID     = 1'b0;
            en_ID_EX     = 1'b0;
            en_EX_MEM    = 1'b0;
            en_MEM_WB    = 1'b0;
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_EX_MEM = 1'b1;
            flush_MEM_WB = 1'b1;
            state_nxt    = RUN;
            wait_nxt     = '0;
        end else if (state == ERR) begin
            mem_req   = 1'b0;
            pc_en     = 1'b0;
            en_IF_ID  = 1'b0;
            en_ID_EX  = 1'b0;
            en_EX_MEM = 1'b0;
            en_MEM_WB = 1'b0;
        end else if (mem_stall) begin
            // Freeze upstream, let WB drain with a bubble.
            pc_en        = 1'b0;
            en_IF_ID     = 1'b0;
            en_ID_EX     = 1'b0;
            en_EX_MEM    = 1'b0;
            flush_MEM_WB = 1'b1;
            wait_nxt     = wait_inc;
            state_nxt    = (wait_inc >= WAIT_W'(MAX_WAIT)) ? ERR : MEM_WAIT;
        end else begin
            state_nxt = RUN;
            wait_nxt  = '0;
            if (br_taken) begin
                pc_src       = 1'b1;
                flush_IF_ID  = 1'b1;
                flush_ID_EX  = 1'b1;
                flush_EX_MEM = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                en_IF_ID    = 1'b0;
                flush_ID_EX = 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_q <= '0;
        end else if (!pc_en && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, load-use, branch priority, mem stall/ack, timeout to ERR, stall count.
module tb_pipe_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MemRead_EX, uses_rt_ID, Branch_MEM, ZERO_MEM, MemRead_MEM, MemWrite_MEM, mem_ack;
    logic [4:0]  wrin_EX, rs_ID, rt_ID;
    logic        mem_req, pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB;
    logic        flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, pc_src, mem_err;
    logic [15:0] stall_cnt;
    logic [11:0] ctl;

    int tests = 0;
    int fails = 0;

    // {pc_en,en_IF_ID,en_ID_EX,en_EX_MEM,en_MEM_WB}, {flush IF,ID,EX,WB}, {pc_src,mem_req,mem_err}
    localparam logic [11:0] P_RST   = {5'b00000, 4'b1111, 3'b000};
    localparam logic [11:0] P_NORM  = {5'b11111, 4'b0000, 3'b000};
    localparam logic [11:0] P_LU    = {5'b00111, 4'b0100, 3'b000};
    localparam logic [11:0] P_BR    = {5'b11111, 4'b1110, 3'b100};
    localparam logic [11:0] P_STALL = {5'b00001, 4'b0001, 3'b010};
    localparam logic [11:0] P_ACK   = {5'b11111, 4'b0000, 3'b010};
    localparam logic [11:0] P_ERR   = {5'b00000, 4'b0000, 3'b001};

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [15:0] EXP_STALLS = 16'd5;
`else
    localparam logic [15:0] EXP_STALLS = 16'd0;
`endif

    pipe_ctrl dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .MemRead_EX   (MemRead_EX),
        .wrin_EX      (wrin_EX),
        .rs_ID        (rs_ID),
        .rt_ID        (rt_ID),
        .uses_rt_ID   (uses_rt_ID),
        .Branch_MEM   (Branch_MEM),
        .ZERO_MEM     (ZERO_MEM),
        .MemRead_MEM  (MemRead_MEM),
        .MemWrite_MEM (MemWrite_MEM),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .pc_en        (pc_en),
        .en_IF_ID     (en_IF_ID),
        .en_ID_EX     (en_ID_EX),
        .en_EX_MEM    (en_EX_MEM),
        .en_MEM_WB    (en_MEM_WB),
        .flush_IF_ID  (flush_IF_ID),
        .flush_ID_EX  (flush_ID_EX),
        .flush_EX_MEM (flush_EX_MEM),
        .flush_MEM_WB (flush_MEM_WB),
        .pc_src       (pc_src),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt)
    );

    always #5 CLK = ~CLK;

    assign ctl = {pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB,
                  flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
                  pc_src, mem_req, mem_err};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        MemRead_EX   = 1'b0;
        wrin_EX      = 5'd0;
        rs_ID        = 5'd0;
        rt_ID        = 5'd0;
        uses_rt_ID   = 1'b0;
        Branch_MEM   = 1'b0;
        ZERO_MEM     = 1'b0;
        MemRead_MEM  = 1'b0;
        MemWrite_MEM = 1'b0;
        mem_ack      = 1'b0;
    endtask

    initial begin
        clr();
        RESET       = 1'b1;
        MemRead_MEM = 1'b1;
        tick();
        chk("reset_outputs", 16'(ctl), 16'(P_RST));
        chk("reset_stall_cnt", stall_cnt, 16'd0);

        clr();
        RESET = 1'b0;
        #1 chk("idle_normal", 16'(ctl), 16'(P_NORM));
        tick();

        // Load-use on rs, one cycle, then normal.
        MemRead_EX = 1'b1; wrin_EX = 5'd5; rs_ID = 5'd5;
        #1 chk("loaduse_rs", 16'(ctl), 16'(P_LU));
        tick();
        clr();
        #1 chk("loaduse_after", 16'(ctl), 16'(P_NORM));
        tick();

        // Load-use on rt only when rt is used.
        MemRead_EX = 1'b1; wrin_EX = 5'd7; rs_ID = 5'd3; rt_ID = 5'd7; uses_rt_ID = 1'b1;
        #1 chk("loaduse_rt", 16'(ctl), 16'(P_LU));
        tick();
        uses_rt_ID = 1'b0;
        #1 chk("rt_unused", 16'(ctl), 16'(P_NORM));
        tick();

        // Register 0 never hazards.
        MemRead_EX = 1'b1; wrin_EX = 5'd0; rs_ID = 5'd0; rt_ID = 5'd0; uses_rt_ID = 1'b1;
        #1 chk("reg0_no_stall", 16'(ctl), 16'(P_NORM));
        tick();

        // Branch taken beats load-use; untaken branch leaves load-use in force.
        MemRead_EX = 1'b1; wrin_EX = 5'd5; rs_ID = 5'd5; uses_rt_ID = 1'b0;
        Branch_MEM = 1'b1; ZERO_MEM = 1'b1;
        #1 chk("branch_over_loaduse", 16'(ctl), 16'(P_BR));
        ZERO_MEM = 1'b0;
        #1 chk("branch_not_taken_lu", 16'(ctl), 16'(P_LU));
        MemRead_EX = 1'b0;
        #1 chk("branch_not_taken", 16'(ctl), 16'(P_NORM));
        tick();

        // Mem stall for 3 cycles with a taken branch pending: pc_src stays 0.
        clr();
        MemRead_MEM = 1'b1; Branch_MEM = 1'b1; ZERO_MEM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("memstall_%0d", i), 16'(ctl), 16'(P_STALL));
            tick();
        end
        Branch_MEM = 1'b0; ZERO_MEM = 1'b0; mem_ack = 1'b1;
        #1 chk("mem_ack_release", 16'(ctl), 16'(P_ACK));
        tick();
        clr();
        #1 chk("after_ack_normal", 16'(ctl), 16'(P_NORM));
        chk("stall_cnt_total", stall_cnt, EXP_STALLS);
        tick();

        // Write never acked: 15 stalled cycles, then ERR.
        MemWrite_MEM = 1'b1;
        for (int i = 0; i < 15; i++) begin
            #1 chk($sformatf("timeout_wait_%0d", i), 16'(ctl), 16'(P_STALL));
            tick();
        end
        #1 chk("err_entered", 16'(ctl), 16'(P_ERR));
        mem_ack = 1'b1; Branch_MEM = 1'b1; ZERO_MEM = 1'b1;
        tick();
        tick();
        #1 chk("err_sticky", 16'(ctl), 16'(P_ERR));

        // Reset leaves ERR, drops mem_req despite pending write.
        RESET = 1'b1;
        tick();
        chk("err_reset", 16'(ctl), 16'(P_RST));
        chk("err_reset_cnt", stall_cnt, 16'd0);
        RESET = 1'b0;
        clr();
        #1 chk("post_err_normal", 16'(ctl), 16'(P_NORM));
        tick();

        // Reset during MEM_WAIT abandons the access at once.
        MemRead_MEM = 1'b1;
        tick();
        tick();
        #1 chk("memwait_stall", 16'(ctl), 16'(P_STALL));
        RESET = 1'b1;
        #1 chk("memwait_reset_now", 16'(ctl), 16'(P_RST));
        tick();
        chk("memwait_reset_edge", 16'(ctl), 16'(P_RST));
        RESET = 1'b0;
        clr();
        #1 chk("memwait_reset_done", 16'(ctl), 16'(P_NORM));
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
